// File: rtl/lane_share_pkg.sv
// Shared types and constants for the lane_share_arbiter slice.
// Optional burst lock is enabled with the ARB_BURST_LOCK_EN macro.
package lane_share_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_C = 1'b1;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_C = 2'd2
    } state_t;

endpackage

// File: rtl/lane_share_rr_pick.sv
// Combinational 2-way round-robin picker; bit 0 = A side, bit 1 = C side.
module lane_share_rr_pick
    import lane_share_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       lock_en,
    input  logic       lock_src,
    output logic [1:0] gnt
);

    // A held lock only ever grants the locked side, even if it is idle.
    always_comb begin
        gnt = 2'b00;
        if (lock_en) begin
            if (lock_src == SRC_C) begin
                gnt[1] = req[1];
            end else begin
                gnt[0] = req[0];
            end
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == SRC_C) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/lane_share_arbiter.sv
// Round-robin share of one registered lane between A and C requesters.
// Define ARB_BURST_LOCK_EN to add a_last/c_last and burst locking.
module lane_share_arbiter
    import lane_share_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    output logic             c_ready,
`ifdef ARB_BURST_LOCK_EN
    input  logic             a_last,
    input  logic             c_last,
`endif
    output logic             s_valid,
    output logic [WIDTH-1:0] s_data,
    output logic             s_src,
    input  logic             s_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             w_prio_nxt;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    logic             r_s_src;
    logic             w_load;
    logic [1:0]       w_gnt;
    logic             w_lock_en;
    logic             w_lock_src;
    logic             w_acc_a;
    logic             w_acc_c;
    logic             w_a_last;
    logic             w_c_last;

`ifdef ARB_BURST_LOCK_EN
    assign w_a_last = a_last;
    assign w_c_last = c_last;
`else
    assign w_a_last = 1'b1;
    assign w_c_last = 1'b1;
`endif

    assign w_load     = ~r_s_valid | s_ready;
    assign w_lock_en  = (r_state != ST_ARB);
    assign w_lock_src = (r_state == ST_LOCK_C) ? SRC_C : SRC_A;

    lane_share_rr_pick u_pick (
        .req      ({c_valid, a_valid}),
        .prio     (r_prio),
        .lock_en  (w_lock_en),
        .lock_src (w_lock_src),
        .gnt      (w_gnt)
    );

    // Readies are forced low while reset is asserted.
    assign a_ready = rst_n & w_load & w_gnt[0];
    assign c_ready = rst_n & w_load & w_gnt[1];
    assign w_acc_a = a_valid & a_ready;
    assign w_acc_c = c_valid & c_ready;

    // Next state and priority; priority only flips at the end of a burst.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        if (w_acc_a && w_a_last) begin
            w_prio_nxt = SRC_C;
        end else if (w_acc_c && w_c_last) begin
            w_prio_nxt = SRC_A;
        end
`ifdef ARB_BURST_LOCK_EN
        case (r_state)
            ST_ARB: begin
                if (w_acc_a && !w_a_last) begin
                    w_state_nxt = ST_LOCK_A;
                end else if (w_acc_c && !w_c_last) begin
                    w_state_nxt = ST_LOCK_C;
                end
            end
            ST_LOCK_A: if (w_acc_a && w_a_last) w_state_nxt = ST_ARB;
            ST_LOCK_C: if (w_acc_c && w_c_last) w_state_nxt = ST_ARB;
            default:   w_state_nxt = ST_ARB;
        endcase
`else
        w_state_nxt = ST_ARB;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_prio  <= SRC_A;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Output slot: replaced on accept, emptied when drained without a refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_src   <= SRC_A;
        end else if (w_acc_a) begin
            r_s_valid <= 1'b1;
            r_s_data  <= a_data;
            r_s_src   <= SRC_A;
        end else if (w_acc_c) begin
            r_s_valid <= 1'b1;
            r_s_data  <= c_data;
            r_s_src   <= SRC_C;
        end else if (s_ready) begin
            r_s_valid <= 1'b0;
        end
    end

    assign s_valid = r_s_valid;
    assign s_data  = r_s_data;
    assign s_src   = r_s_src;

endmodule
